// File: rtl/pipeline_hazard_ctrl_if.sv
// Issue-point bus between the decode/execute issue stage and the hazard controller.
// The master side presents the instruction at stage 0; the slave side returns PC and flow control.
interface pipeline_hazard_ctrl_if #(
   parameter int STAGES = 6,
   parameter int REG_W  = 4
);
   logic                 issue_valid;
   logic                 issue_wr;
   logic                 issue_ld;
   logic [REG_W-1:0]     issue_rd;
   logic [3*REG_W-1:0]   issue_src;
   logic [2:0]           issue_src_used;
   logic                 branch_taken;
   logic                 issue_ready;
   logic                 load_pc;
   logic [1:0]           sel_pc;
   logic [STAGES-1:0]    stage_valid;
   logic [15:0]          stall_cnt;

   modport master (
      output issue_valid, issue_wr, issue_ld, issue_rd, issue_src, issue_src_used, branch_taken,
      input  issue_ready, load_pc, sel_pc, stage_valid, stall_cnt
   );

   modport slave (
      input  issue_valid, issue_wr, issue_ld, issue_rd, issue_src, issue_src_used, branch_taken,
      output issue_ready, load_pc, sel_pc, stage_valid, stall_cnt
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: boot PC load, refetch fill after redirects, per-stage tracking of
// in-flight destinations, RAW stall detection (stall-always or load-only) and branch flush.
module pipeline_hazard_ctrl #(
   parameter int STAGES       = 6,
   parameter int REG_W        = 4,
   parameter int BRANCH_STAGE = 2,
   parameter int FETCH_LAT    = 2,
   parameter int FORWARD      = 0,
   parameter int LOAD_READY   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   pipeline_hazard_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {BOOT, FILL, RUN} state_e;

   state_e                        state_q, state_d;
   logic [2:0]                    fill_cnt_q, fill_cnt_d;
   logic [15:0]                   stall_cnt_q, stall_cnt_d;
   logic [STAGES-1:1]             vld_q, vld_d;
   logic [STAGES-1:1]             wr_q, wr_d;
   logic [STAGES-1:1]             ld_q, ld_d;
   logic [STAGES-1:1][REG_W-1:0]  rd_q, rd_d;

   logic       hazard;
   logic       branch_accept;
   logic       issue_ready;
   logic       load_pc;
   logic [1:0] sel_pc;

   assign branch_accept = bus.branch_taken & vld_q[BRANCH_STAGE];

   // In forwarding mode only a load that has not yet reached LOAD_READY blocks a consumer.
   always_comb begin
      hazard = 1'b0;
      for (int k = 1; k < STAGES; k++) begin
         for (int j = 0; j < 3; j++) begin
            if (bus.issue_src_used[j] && vld_q[k] && wr_q[k] &&
                rd_q[k] == bus.issue_src[j*REG_W +: REG_W] &&
                (FORWARD == 0 || (ld_q[k] && k < LOAD_READY)))
               hazard = 1'b1;
         end
      end
   end

   assign issue_ready = (state_q == RUN) & bus.issue_valid & ~hazard & ~branch_accept;

   always_comb begin
      state_d    = state_q;
      fill_cnt_d = fill_cnt_q;
      load_pc    = 1'b0;
      sel_pc     = 2'b00;
      case (state_q)
         BOOT: begin
            state_d    = FILL;
            fill_cnt_d = 3'(FETCH_LAT);
            load_pc    = 1'b1;
            sel_pc     = 2'b01;
         end
         FILL: begin
            fill_cnt_d = fill_cnt_q - 3'd1;
            if (fill_cnt_q == 3'd1)
               state_d = RUN;
         end
         RUN: begin
            if (issue_ready)
               load_pc = 1'b1;
         end
         default: state_d = BOOT;
      endcase
      // A redirect restarts the fetch bubble regardless of where the sequencer was.
      if (branch_accept && state_q != BOOT) begin
         state_d    = FILL;
         fill_cnt_d = 3'(FETCH_LAT);
         load_pc    = 1'b1;
         sel_pc     = 2'b10;
      end
   end

   always_comb begin
      vld_d[1] = issue_ready;
      wr_d[1]  = bus.issue_wr;
      ld_d[1]  = bus.issue_ld;
      rd_d[1]  = bus.issue_rd;
      for (int k = 2; k < STAGES; k++) begin
         // Instructions younger than the branch are squashed as they move down.
         vld_d[k] = vld_q[k-1] & ~(branch_accept && k <= BRANCH_STAGE);
         wr_d[k]  = wr_q[k-1];
         ld_d[k]  = ld_q[k-1];
         rd_d[k]  = rd_q[k-1];
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (state_q == RUN && bus.issue_valid && hazard && !branch_accept &&
          stall_cnt_q != 16'hFFFF)
         stall_cnt_d = stall_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= BOOT;
         fill_cnt_q  <= '0;
         stall_cnt_q <= '0;
         vld_q       <= '0;
         wr_q        <= '0;
         ld_q        <= '0;
         rd_q        <= '0;
      end else begin
         state_q     <= state_d;
         fill_cnt_q  <= fill_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         vld_q       <= vld_d;
         wr_q        <= wr_d;
         ld_q        <= ld_d;
         rd_q        <= rd_d;
      end
   end

   assign bus.issue_ready = issue_ready;
   assign bus.load_pc     = load_pc;
   assign bus.sel_pc      = sel_pc;
   assign bus.stage_valid = {vld_q, issue_ready};
   assign bus.stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: three instances (stall-always, load-forwarding, 16-stage)
// share one stimulus stream; expected issue cycles go through per-instance queues.
module tb_pipeline_hazard_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int q0[$];
   int q1[$];
   int q2[$];

   pipeline_hazard_ctrl_if #(.STAGES(6),  .REG_W(4)) b0 ();
   pipeline_hazard_ctrl_if #(.STAGES(6),  .REG_W(4)) b1 ();
   pipeline_hazard_ctrl_if #(.STAGES(16), .REG_W(4)) b2 ();

   pipeline_hazard_ctrl #(.STAGES(6), .REG_W(4), .BRANCH_STAGE(2), .FETCH_LAT(2),
                          .FORWARD(0), .LOAD_READY(4)) u_dut0 (.clk(clk), .rst(rst), .bus(b0));
   pipeline_hazard_ctrl #(.STAGES(6), .REG_W(4), .BRANCH_STAGE(2), .FETCH_LAT(2),
                          .FORWARD(1), .LOAD_READY(4)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
   pipeline_hazard_ctrl #(.STAGES(16), .REG_W(4), .BRANCH_STAGE(2), .FETCH_LAT(2),
                          .FORWARD(0), .LOAD_READY(4)) u_dut2 (.clk(clk), .rst(rst), .bus(b2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic wr, input logic ld, input logic [3:0] rd,
                        input logic [11:0] src, input logic [2:0] used, input logic bt);
      b0.issue_valid = v;  b0.issue_wr = wr; b0.issue_ld = ld; b0.issue_rd = rd;
      b0.issue_src = src;  b0.issue_src_used = used; b0.branch_taken = bt;
      b1.issue_valid = v;  b1.issue_wr = wr; b1.issue_ld = ld; b1.issue_rd = rd;
      b1.issue_src = src;  b1.issue_src_used = used; b1.branch_taken = bt;
      b2.issue_valid = v;  b2.issue_wr = wr; b2.issue_ld = ld; b2.issue_rd = rd;
      b2.issue_src = src;  b2.issue_src_used = used; b2.branch_taken = bt;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic smp();
      #2;
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b0, 1'b0, 4'd0, 12'd0, 3'd0, 1'b0);
      rst = 1'b1;
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
   endtask

   // Holds current inputs until every watched instance issues, then checks the cycle
   // against the queued expectation. Returns in the issuing cycle, before its edge.
   task automatic run_issue(input bit use2);
      int g0 = -1;
      int g1 = -1;
      int g2 = -1;
      for (int n = 0; n < 40; n++) begin
         if (g0 < 0 && b0.issue_ready) g0 = cyc;
         if (g1 < 0 && b1.issue_ready) g1 = cyc;
         if (use2 && g2 < 0 && b2.issue_ready) g2 = cyc;
         if (g0 >= 0 && g1 >= 0 && (!use2 || g2 >= 0)) break;
         tick();
         smp();
      end
      chk("issue_cyc_fwd0", g0, q0.pop_front());
      chk("issue_cyc_fwd1", g1, q1.pop_front());
      if (use2) chk("issue_cyc_s16", g2, q2.pop_front());
   endtask

   initial begin
      drive(1'b0, 1'b0, 1'b0, 4'd0, 12'd0, 3'd0, 1'b0);
      #1;
      chk("rst_load_pc", b0.load_pc, 1);
      chk("rst_sel_pc", b0.sel_pc, 2'b01);
      chk("rst_stage_valid", b0.stage_valid, 0);

      // Boot: first issue at FETCH_LAT+1
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 4'd0, 12'd0, 3'd0, 1'b0);
      smp();
      chk("boot_load_pc", b0.load_pc, 1);
      chk("boot_sel_pc", b0.sel_pc, 2'b01);
      chk("boot_ready", b0.issue_ready, 0);
      chk("boot_s16_load_pc", b2.load_pc, 1);
      q0.push_back(3); q1.push_back(3); q2.push_back(3);
      run_issue(1'b1);
      chk("run_sel_pc", b0.sel_pc, 2'b00);
      chk("run_load_pc", b0.load_pc, 1);

      // RAW on a plain ALU producer: stall-always waits STAGES, forwarding does not stall
      do_reset();
      tick(); tick(); tick();
      drive(1'b1, 1'b1, 1'b0, 4'd3, 12'd0, 3'd0, 1'b0);
      smp();
      chk("raw_prod_fwd0", b0.issue_ready, 1);
      chk("raw_prod_fwd1", b1.issue_ready, 1);
      tick();
      drive(1'b1, 1'b0, 1'b0, 4'd0, 12'h003, 3'b001, 1'b0);
      smp();
      q0.push_back(9); q1.push_back(4);
      run_issue(1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 4'd0, 12'd0, 3'd0, 1'b0);
      smp();
      chk("raw_stall_fwd0", b0.stall_cnt, 5);
      chk("raw_stall_fwd1", b1.stall_cnt, 0);

      // Load-use through the rs slot
      do_reset();
      tick(); tick(); tick();
      drive(1'b1, 1'b1, 1'b1, 4'd2, 12'd0, 3'd0, 1'b0);
      tick();
      drive(1'b1, 1'b0, 1'b0, 4'd0, 12'h200, 3'b100, 1'b0);
      smp();
      q0.push_back(9); q1.push_back(7);
      run_issue(1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 4'd0, 12'd0, 3'd0, 1'b0);
      smp();
      chk("ld_stall_fwd0", b0.stall_cnt, 5);
      chk("ld_stall_fwd1", b1.stall_cnt, 3);

      // Matching register in an unused source slot is not a hazard
      do_reset();
      tick(); tick(); tick();
      drive(1'b1, 1'b1, 1'b0, 4'd5, 12'd0, 3'd0, 1'b0);
      tick();
      drive(1'b1, 1'b0, 1'b0, 4'd0, 12'h050, 3'b101, 1'b0);
      smp();
      q0.push_back(4); q1.push_back(4);
      run_issue(1'b0);

      // Branch flush from stage 2
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 4'd0, 12'd0, 3'd0, 1'b0);
      smp();
      q0.push_back(3); q1.push_back(3);
      run_issue(1'b0);
      tick(); tick();
      drive(1'b1, 1'b0, 1'b0, 4'd0, 12'd0, 3'd0, 1'b1);
      smp();
      chk("br_load_pc", b0.load_pc, 1);
      chk("br_sel_pc", b0.sel_pc, 2'b10);
      chk("br_ready", b0.issue_ready, 0);
      chk("br_stage_valid", b0.stage_valid, 6'b000110);
      tick();
      drive(1'b1, 1'b0, 1'b0, 4'd0, 12'd0, 3'd0, 1'b0);
      smp();
      chk("br_flush_fwd0", b0.stage_valid, 6'b001000);
      chk("br_flush_fwd1", b1.stage_valid, 6'b001000);
      chk("br_fill_load_pc", b0.load_pc, 0);
      q0.push_back(8); q1.push_back(8);
      run_issue(1'b0);

      // Ignored branch, then branch beating a hazard
      do_reset();
      tick(); tick(); tick();
      drive(1'b0, 1'b0, 1'b0, 4'd0, 12'd0, 3'd0, 1'b1);
      smp();
      chk("br_ignored_load_pc", b0.load_pc, 0);
      tick();
      drive(1'b1, 1'b0, 1'b0, 4'd0, 12'd0, 3'd0, 1'b0);
      tick();
      drive(1'b1, 1'b1, 1'b0, 4'd7, 12'd0, 3'd0, 1'b0);
      tick();
      drive(1'b1, 1'b0, 1'b0, 4'd0, 12'h007, 3'b001, 1'b1);
      smp();
      chk("prio_load_pc", b0.load_pc, 1);
      chk("prio_sel_pc", b0.sel_pc, 2'b10);
      chk("prio_ready", b0.issue_ready, 0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 4'd0, 12'd0, 3'd0, 1'b0);
      smp();
      chk("prio_stall_cnt", b0.stall_cnt, 0);

      // Self-dependent writer chain held for 70000 cycles
      do_reset();
      tick(); tick(); tick();
      drive(1'b1, 1'b1, 1'b0, 4'd1, 12'h001, 3'b001, 1'b0);
      for (int n = 0; n < 70000; n++) tick();
      drive(1'b0, 1'b0, 1'b0, 4'd0, 12'd0, 3'd0, 1'b0);
      smp();
      chk("sat_s16", b2.stall_cnt, 16'hFFFF);
      chk("chain_fwd0", b0.stall_cnt, 58333);
      chk("chain_fwd1", b1.stall_cnt, 0);

      // Reset with a full pipeline
      drive(1'b1, 1'b0, 1'b0, 4'd0, 12'd0, 3'd0, 1'b0);
      tick(); tick(); tick(); tick(); tick();
      smp();
      chk("full_stage_valid", b0.stage_valid, 6'h3F);
      rst = 1'b1;
      #1;
      chk("mid_rst_stage_valid", b0.stage_valid, 0);
      chk("mid_rst_ready", b0.issue_ready, 0);
      chk("mid_rst_load_pc", b0.load_pc, 1);
      chk("mid_rst_sel_pc", b0.sel_pc, 2'b01);
      chk("mid_rst_stall_s16", b2.stall_cnt, 0);
      chk("mid_rst_stall_fwd0", b0.stall_cnt, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
      smp();
      chk("reboot_sel_pc", b0.sel_pc, 2'b01);
      q0.push_back(3); q1.push_back(3); q2.push_back(3);
      run_issue(1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
